// File: rtl/fm_pkg.sv
// Shared constants and state type for the FM waveform ROM reader.
// The ROM wrapper instance uses the same widths and latency.
package fm_pkg;

    localparam int ADDR_W  = 11;
    localparam int DATA_W  = 14;
    localparam int PHASE_W = 24;
    localparam int ROM_LAT = 2;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        RUN   = 2'd1,
        DRAIN = 2'd2
    } fm_rd_state_t;

endpackage

// File: rtl/fm_rom_reader_if.sv
// ROM read bus plus the valid/ready sample stream toward the DAC datapath.
// master = reader side, slave = ROM / sample consumer side.
interface fm_rom_reader_if #(
    parameter int ADDR_W = fm_pkg::ADDR_W,
    parameter int DATA_W = fm_pkg::DATA_W
);
    logic [ADDR_W-1:0] rom_address;
    logic [DATA_W-1:0] rom_q;
    logic [DATA_W-1:0] sample_data;
    logic              sample_valid;
    logic              sample_ready;

    modport master (
        output rom_address, sample_data, sample_valid,
        input  rom_q, sample_ready
    );

    modport slave (
        input  rom_address, sample_data, sample_valid,
        output rom_q, sample_ready
    );
endinterface

// File: rtl/fm_sample_fifo.sv
// Small synchronous FIFO with occupancy output. Head data reads as zero while
// empty so the stream data is clean after reset and between runs.
module fm_sample_fifo #(
    parameter int DEPTH = 4,
    parameter int WIDTH = 14,
    parameter int AW    = (DEPTH > 1) ? $clog2(DEPTH) : 1,
    parameter int CW    = $clog2(DEPTH + 1)
) (
    input  logic             clock,
    input  logic             reset,
    input  logic             push,
    input  logic [WIDTH-1:0] push_data,
    input  logic             pop,
    output logic [WIDTH-1:0] pop_data,
    output logic             valid,
    output logic [CW-1:0]    level
);
    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW-1:0]    wr_ptr, rd_ptr;
    logic             wr_en, rd_en;

    assign wr_en    = push && (level != CW'(DEPTH));
    assign rd_en    = pop && (level != '0);
    assign valid    = (level != '0);
    assign pop_data = valid ? mem[rd_ptr] : '0;

    // storage write; contents need no reset since level gates the head
    always_ff @(posedge clock) begin
        if (wr_en) mem[wr_ptr] <= push_data;
    end

    // pointers and occupancy
    always_ff @(posedge clock) begin
        if (reset) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            level  <= '0;
        end else begin
            if (wr_en) wr_ptr <= (wr_ptr == AW'(DEPTH - 1)) ? '0 : wr_ptr + AW'(1);
            if (rd_en) rd_ptr <= (rd_ptr == AW'(DEPTH - 1)) ? '0 : rd_ptr + AW'(1);
            case ({wr_en, rd_en})
                2'b10:   level <= level + CW'(1);
                2'b01:   level <= level - CW'(1);
                default: level <= level;
            endcase
        end
    end
endmodule

// File: rtl/fm_rom_reader.sv
// Streaming reader for the FM waveform ROM: phase accumulator issues one
// address per cycle, a valid shift register tracks the fixed ROM latency and
// pushes returned words into the sample FIFO. Issue is gated by a credit check
// so the FIFO can never overflow under backpressure.
module fm_rom_reader #(
    parameter int ADDR_W     = fm_pkg::ADDR_W,
    parameter int DATA_W     = fm_pkg::DATA_W,
    parameter int PHASE_W    = fm_pkg::PHASE_W,
    parameter int ROM_LAT    = fm_pkg::ROM_LAT,
    parameter int FIFO_DEPTH = 4,
    parameter int CNT_W      = 16
) (
    input  logic               clock,
    input  logic               reset,
    input  logic               start,
    input  logic               stop,
    input  logic [PHASE_W-1:0] step,
    input  logic [CNT_W-1:0]   count,
    output logic               busy,
    output logic               done,
    fm_rom_reader_if.master    bus
);
    import fm_pkg::*;

    localparam int FCW = $clog2(FIFO_DEPTH + 1);
    localparam int CRW = $clog2(FIFO_DEPTH + ROM_LAT + 1);

    fm_rd_state_t       state;
    logic [PHASE_W-1:0] phase, step_q;
    logic [CNT_W-1:0]   count_q, issued;
    logic [ROM_LAT-1:0] vld_pipe;
    logic [FCW-1:0]     fifo_count;
    logic [CRW-1:0]     in_flight;
    logic               issue, last_issue, push, pop, drained;

    // words issued to the ROM but not yet pushed into the FIFO
    always_comb begin
        in_flight = '0;
        for (int i = 0; i < ROM_LAT; i++)
            in_flight = in_flight + CRW'(vld_pipe[i]);
    end

    // the word pushing this cycle is still in in_flight, so it already counts
    // against the limit; a pop this cycle deliberately does not free a slot
    assign issue      = (state == RUN) &&
                        ((in_flight + CRW'(fifo_count)) < CRW'(FIFO_DEPTH));
    assign last_issue = (count_q != '0) && ((issued + CNT_W'(1)) == count_q);
    assign push       = vld_pipe[ROM_LAT-1];
    assign pop        = bus.sample_valid && bus.sample_ready;
    // look one cycle ahead so done lands on the cycle after the final transfer
    assign drained    = (in_flight == '0) &&
                        ((fifo_count == '0) || ((fifo_count == FCW'(1)) && pop));
    assign busy       = (state != IDLE);

    // run control: IDLE -> RUN -> DRAIN -> IDLE, done pulses on the last edge
    always_ff @(posedge clock) begin
        if (reset) begin
            state   <= IDLE;
            done    <= 1'b0;
            step_q  <= '0;
            count_q <= '0;
        end else begin
            done <= 1'b0;
            case (state)
                IDLE: if (start) begin
                    state   <= RUN;
                    step_q  <= step;
                    count_q <= count;
                end
                RUN: if (stop || (issue && last_issue)) state <= DRAIN;
                DRAIN: if (drained) begin
                    state <= IDLE;
                    done  <= 1'b1;
                end
                default: state <= IDLE;
            endcase
        end
    end

    // phase accumulator and address issue; phase holds while stalled
    always_ff @(posedge clock) begin
        if (reset) begin
            phase           <= '0;
            issued          <= '0;
            bus.rom_address <= '0;
        end else if (state == IDLE && start) begin
            phase  <= '0;
            issued <= '0;
        end else if (issue) begin
            bus.rom_address <= phase[PHASE_W-1 -: ADDR_W];
            phase           <= phase + step_q;
            issued          <= issued + CNT_W'(1);
        end
    end

    // ROM latency tracker: bit ROM_LAT-1 marks rom_q as valid this cycle
    always_ff @(posedge clock) begin
        if (reset) begin
            vld_pipe <= '0;
        end else begin
            vld_pipe[0] <= issue;
            for (int i = 1; i < ROM_LAT; i++)
                vld_pipe[i] <= vld_pipe[i-1];
        end
    end

    fm_sample_fifo #(
        .DEPTH (FIFO_DEPTH),
        .WIDTH (DATA_W)
    ) u_fifo (
        .clock     (clock),
        .reset     (reset),
        .push      (push),
        .push_data (bus.rom_q),
        .pop       (pop),
        .pop_data  (bus.sample_data),
        .valid     (bus.sample_valid),
        .level     (fifo_count)
    );
endmodule

// File: tb/tb_fm_rom_reader.sv
// Bench for fm_rom_reader: ROM model word[i] = i ^ 0x2AAA with 2-cycle latency,
// a sample-sequence model (k-th sample from k*step), directed and random runs.
module tb_fm_rom_reader;
    import fm_pkg::*;

    logic               clock = 1'b0;
    logic               reset, start, stop;
    logic [PHASE_W-1:0] step;
    logic [15:0]        count;
    logic               busy, done;

    fm_rom_reader_if bus ();

    fm_rom_reader #(.FIFO_DEPTH(4), .CNT_W(16)) dut (
        .clock (clock),
        .reset (reset),
        .start (start),
        .stop  (stop),
        .step  (step),
        .count (count),
        .busy  (busy),
        .done  (done),
        .bus   (bus)
    );

    always #5 clock = ~clock;

    // ROM model: output register behind the reader's address register
    always @(posedge clock) bus.rom_q <= {3'b000, bus.rom_address} ^ 14'h2AAA;

    int cyc = 0;
    always @(posedge clock) cyc <= cyc + 1;

    int total = 0;
    int bad   = 0;

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got 0x%0h want 0x%0h", nm, act, exp);
        end
    endtask

    // k-th sample of a run: ROM word at the top 11 bits of (k*step mod 2^24)
    function automatic logic [13:0] exp_word(input int k, input logic [23:0] st);
        logic [63:0] ph;
        ph = (64'(k) * 64'(st)) & 64'hFF_FFFF;
        return {3'b000, ph[23:13]} ^ 14'h2AAA;
    endfunction

    // model state and logs
    int          m_k = 0;
    logic [23:0] m_step = '0;
    bit          h_v = 1'b0;
    logic [13:0] h_d;
    bit          prev_x = 1'b0;
    int          xfer_cyc[$];
    logic [13:0] xfer_dat[$];
    int          done_cyc[$];

    // per-cycle compare against the model
    always @(negedge clock) begin
        if (reset) begin
            h_v    = 1'b0;
            prev_x = 1'b0;
        end else begin
            if (h_v) begin
                chk("hold_valid", 64'(bus.sample_valid), 64'd1);
                chk("hold_data", 64'(bus.sample_data), 64'(h_d));
            end
            if (done) begin
                chk("done_after_xfer", 64'(prev_x), 64'd1);
                chk("done_busy_low", 64'(busy), 64'd0);
                done_cyc.push_back(cyc);
            end
            prev_x = bus.sample_valid && bus.sample_ready;
            if (prev_x) begin
                chk("sample_seq", 64'(bus.sample_data), 64'(exp_word(m_k, m_step)));
                m_k++;
                xfer_cyc.push_back(cyc);
                xfer_dat.push_back(bus.sample_data);
            end
            h_v = bus.sample_valid && !bus.sample_ready;
            h_d = bus.sample_data;
        end
    end

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    // one-cycle start pulse; returns the cycle number of the start cycle
    task automatic start_run(input logic [23:0] st, input logic [15:0] cnt,
                             input bit with_stop, output int s);
        tick();
        step  = st;
        count = cnt;
        start = 1'b1;
        stop  = with_stop;
        m_step = st;
        m_k    = 0;
        xfer_cyc.delete();
        xfer_dat.delete();
        done_cyc.delete();
        s = cyc;
        tick();
        start = 1'b0;
        stop  = 1'b0;
    endtask

    task automatic wait_idle(input int budget, input bit rnd);
        int n;
        n = 0;
        while (done_cyc.size() == 0 && n < budget) begin
            if (rnd) bus.sample_ready = 1'($urandom_range(0, 1));
            tick();
            n++;
        end
        bus.sample_ready = 1'b1;
        tick();
        chk("done_pulses", 64'(done_cyc.size()), 64'd1);
        chk("idle_busy", 64'(busy), 64'd0);
    endtask

    task automatic chk_outputs_zero(input string tag);
        chk({tag, "_addr"},  64'(bus.rom_address),  64'd0);
        chk({tag, "_busy"},  64'(busy),             64'd0);
        chk({tag, "_done"},  64'(done),             64'd0);
        chk({tag, "_valid"}, 64'(bus.sample_valid), 64'd0);
        chk({tag, "_data"},  64'(bus.sample_data),  64'd0);
    endtask

    logic [13:0] exp_lin  [5] = '{14'h2AAA, 14'h2AAB, 14'h2AA8, 14'h2AA9, 14'h2AAE};
    logic [13:0] exp_wrap [4] = '{14'h2AAA, 14'h2EAA, 14'h2AAA, 14'h2EAA};

    initial begin
        #600000;
        $display("FAIL watchdog: bench did not finish in time");
        $fatal(1, "watchdog expired");
    end

    initial begin
        int s, cnt, nrun;
        logic [23:0] st;

        reset = 1'b1; start = 1'b0; stop = 1'b0;
        step = '0; count = '0; bus.sample_ready = 1'b1;
        repeat (3) tick();
        chk_outputs_zero("rst");
        reset = 1'b0;
        tick();

        // linear read: literal samples, cycle positions and done timing
        start_run(24'd8192, 16'd5, 1'b0, s);
        wait_idle(50, 1'b0);
        chk("lin_n", 64'(xfer_dat.size()), 64'd5);
        for (int i = 0; i < 5 && i < xfer_dat.size(); i++) begin
            chk("lin_data", 64'(xfer_dat[i]), 64'(exp_lin[i]));
            chk("lin_cyc", 64'(xfer_cyc[i]), 64'(s + 4 + i));
        end
        if (done_cyc.size() > 0) chk("lin_done_cyc", 64'(done_cyc[0]), 64'(s + 9));

        // phase wrap
        start_run(24'h800000, 16'd4, 1'b0, s);
        wait_idle(50, 1'b0);
        chk("wrap_n", 64'(xfer_dat.size()), 64'd4);
        for (int i = 0; i < 4 && i < xfer_dat.size(); i++)
            chk("wrap_data", 64'(xfer_dat[i]), 64'(exp_wrap[i]));

        // backpressure: stall, then stop while stalled -> exactly 4 words
        bus.sample_ready = 1'b0;
        start_run(24'd8192, 16'd0, 1'b0, s);
        repeat (10) tick();
        chk("bp_valid", 64'(bus.sample_valid), 64'd1);
        chk("bp_data", 64'(bus.sample_data), 64'h2AAA);
        chk("bp_none", 64'(xfer_dat.size()), 64'd0);
        stop = 1'b1;
        tick();
        stop = 1'b0;
        wait_idle(200, 1'b1);
        chk("bp_n", 64'(xfer_dat.size()), 64'd4);

        // stop in cycle 6 of a continuous run: issues in cycles 1..6
        start_run(24'd8192, 16'd0, 1'b0, s);
        repeat (5) tick();
        stop = 1'b1;
        tick();
        stop = 1'b0;
        wait_idle(50, 1'b0);
        chk("stop_n", 64'(xfer_dat.size()), 64'd6);
        if (done_cyc.size() > 0) chk("stop_done_cyc", 64'(done_cyc[0]), 64'(s + 10));
        if (xfer_dat.size() == 6) chk("stop_last", 64'(xfer_dat[5]), 64'h2AAF);

        // reset mid-run with a full FIFO, then replay from address 0
        bus.sample_ready = 1'b0;
        start_run(24'd8192, 16'd0, 1'b0, s);
        repeat (8) tick();
        reset = 1'b1;
        tick();
        chk_outputs_zero("midrst");
        reset = 1'b0;
        bus.sample_ready = 1'b1;
        start_run(24'd8192, 16'd3, 1'b0, s);
        wait_idle(50, 1'b0);
        chk("replay_n", 64'(xfer_dat.size()), 64'd3);
        for (int i = 0; i < 3 && i < xfer_dat.size(); i++)
            chk("replay_data", 64'(xfer_dat[i]), 64'(exp_lin[i]));

        // start while busy is ignored
        start_run(24'd8192, 16'd6, 1'b0, s);
        tick();
        step = 24'h123456; count = 16'd2; start = 1'b1;
        tick();
        start = 1'b0;
        wait_idle(60, 1'b0);
        chk("ign_n", 64'(xfer_dat.size()), 64'd6);

        // start+stop together in IDLE: start wins
        start_run(24'd8192, 16'd3, 1'b1, s);
        wait_idle(50, 1'b0);
        chk("startstop_n", 64'(xfer_dat.size()), 64'd3);

        // random runs with random backpressure
        for (int r = 0; r < 20; r++) begin
            st  = 24'($urandom);
            cnt = $urandom_range(0, 12);
            start_run(st, 16'(cnt), 1'b0, s);
            if (cnt == 0) begin
                nrun = $urandom_range(3, 30);
                for (int j = 0; j < nrun; j++) begin
                    bus.sample_ready = 1'($urandom_range(0, 1));
                    tick();
                end
                stop = 1'b1;
                tick();
                stop = 1'b0;
                wait_idle(400, 1'b1);
            end else begin
                wait_idle(400, 1'b1);
                chk("rnd_n", 64'(xfer_dat.size()), 64'(cnt));
            end
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
